// File: rtl/dsm_sched_pkg.sv
// Shared state type, ternary sign encodings and the sign decision for the
// time-multiplexed delta-sigma channel scheduler.
package dsm_sched_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, CLEAR} state_t;

   localparam logic [1:0] SIGN_POS  = 2'b01;
   localparam logic [1:0] SIGN_ZERO = 2'b00;
   localparam logic [1:0] SIGN_NEG  = 2'b11;

   // Callers sign-extend their sum to 32 bits before calling.
   function automatic logic [1:0] ternary_sign(input logic signed [31:0] sum);
      if (sum == 0) begin
         return SIGN_ZERO;
      end else if (sum[31]) begin
         return SIGN_NEG;
      end else begin
         return SIGN_POS;
      end
   endfunction

endpackage

// File: rtl/dsm_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping.
// Purely combinational; the caller owns and updates the pointer.
module dsm_rr_arbiter #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   idx
);

   logic [CH_W-1:0] cand;
   logic            found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      // NUM_CH is a power of two, so the index wraps by truncation.
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         cand = ptr + CH_W'(i);
         if (!found && req[cand]) begin
            grant[cand] = 1'b1;
            idx         = cand;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dsm_channel_scheduler.sv
// Shares one first-order ternary noise shaper across NUM_CH channels with a
// per-channel error file. Define DSM_ERR_SAT_EN to clamp the error and add sat_flag.
module dsm_channel_scheduler #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned IN_WIDTH  = 13,
   parameter int unsigned FRAC_BITS = 9,
   parameter int unsigned CH_W      = $clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         clear,
   input  logic [NUM_CH-1:0]            req_valid,
   input  logic [NUM_CH*IN_WIDTH-1:0]   req_data,
   output logic [NUM_CH-1:0]            req_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CH_W-1:0]              out_ch,
   output logic [1:0]                   out_sign,
`ifdef DSM_ERR_SAT_EN
   output logic                         sat_flag,
`endif
   output logic                         busy
);

   import dsm_sched_pkg::*;

   localparam int unsigned SW = IN_WIDTH + 2;
   localparam logic signed [SW-1:0] Step   = SW'(2 ** FRAC_BITS);
   localparam logic signed [SW-1:0] ErrMax = SW'(2 ** (IN_WIDTH - 1) - 1);
   localparam logic signed [SW-1:0] ErrMin = -ErrMax - SW'(1);

   state_t                     state_q, state_d;
   logic [CH_W-1:0]            cnt_q, ptr_q, win_idx;
   logic [NUM_CH-1:0]          win_grant;
   logic signed [IN_WIDTH-1:0] err_q [NUM_CH];
   logic                       can_grant, xfer;
   logic signed [IN_WIDTH-1:0] sel_data, sel_err, new_err;
   logic signed [IN_WIDTH:0]   sum;
   logic signed [SW-1:0]       sum_ext, full;
   logic [1:0]                 sign;

   dsm_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (win_grant),
      .idx   (win_idx)
   );

   assign can_grant = (state_q == RUN) && (!out_valid || out_ready);
   assign req_ready = can_grant ? win_grant : '0;
   assign xfer      = can_grant && (|req_valid);
   assign busy      = (state_q == DRAIN) || (state_q == CLEAR);

   assign sel_data = req_data[win_idx*IN_WIDTH +: IN_WIDTH];
   assign sel_err  = err_q[win_idx];
   assign sum      = {sel_data[IN_WIDTH-1], sel_data} + {sel_err[IN_WIDTH-1], sel_err};
   assign sum_ext  = SW'(sum);
   assign sign     = ternary_sign(32'(sum));

   always_comb begin
      full = sum_ext;
      case (sign)
         SIGN_POS: full = sum_ext - Step;
         SIGN_NEG: full = sum_ext + Step;
         default:  full = sum_ext;
      endcase
   end

`ifdef DSM_ERR_SAT_EN
   logic sat_hit;

   always_comb begin
      sat_hit = 1'b0;
      new_err = full[IN_WIDTH-1:0];
      if (full > ErrMax) begin
         new_err = ErrMax[IN_WIDTH-1:0];
         sat_hit = 1'b1;
      end else if (full < ErrMin) begin
         new_err = ErrMin[IN_WIDTH-1:0];
         sat_hit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_flag <= 1'b0;
      end else if (state_d == CLEAR && state_q != CLEAR) begin
         sat_flag <= 1'b0;
      end else if (xfer && sat_hit) begin
         sat_flag <= 1'b1;
      end
   end
`else
   assign new_err = full[IN_WIDTH-1:0];
`endif

   // clear wins over everything except an in-progress wipe.
   always_comb begin
      state_d = state_q;
      if (clear && state_q != CLEAR) begin
         state_d = DRAIN;
      end else begin
         case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            DRAIN:   if (!out_valid || out_ready) state_d = CLEAR;
            CLEAR:   if (cnt_q == CH_W'(NUM_CH - 1)) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ptr_q     <= CH_W'(NUM_CH - 1);
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_sign  <= SIGN_ZERO;
      end else begin
         state_q <= state_d;
         cnt_q   <= (state_q == CLEAR) ? cnt_q + CH_W'(1) : '0;
         if (xfer) begin
            ptr_q     <= win_idx;
            out_valid <= 1'b1;
            out_ch    <= win_idx;
            out_sign  <= sign;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Writing at the grant edge lets the same channel win again next cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_CH; i++) err_q[i] <= '0;
      end else if (xfer) begin
         err_q[win_idx] <= new_err;
      end else if (state_q == CLEAR) begin
         err_q[cnt_q] <= '0;
      end
   end

endmodule

// File: tb/tb_dsm_channel_scheduler.sv
// Self-checking bench for dsm_channel_scheduler: directed scenarios followed by
// random traffic, all compared against an integer-arithmetic reference model.
module tb_dsm_channel_scheduler;

   localparam int unsigned NUM_CH    = 4;
   localparam int unsigned IN_WIDTH  = 13;
   localparam int unsigned FRAC_BITS = 9;
   localparam int unsigned CH_W      = 2;
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_CLEAR = 3;
   localparam int ERR_HI = (1 << (IN_WIDTH - 1)) - 1;
   localparam int ERR_LO = -(1 << (IN_WIDTH - 1));

   logic                       clk = 1'b0;
   logic                       rst = 1'b0;
   logic                       enable = 1'b0;
   logic                       clear = 1'b0;
   logic                       out_ready = 1'b0;
   logic [NUM_CH-1:0]          req_valid = '0;
   logic [NUM_CH*IN_WIDTH-1:0] req_data = '0;
   logic [NUM_CH-1:0]          req_ready;
   logic                       out_valid;
   logic [CH_W-1:0]            out_ch;
   logic [1:0]                 out_sign;
   logic                       busy;
`ifdef DSM_ERR_SAT_EN
   logic                       sat_flag;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int m_mode, m_cnt, m_ptr, m_ov, m_ch, m_sign, m_sat;
   int m_err [NUM_CH];

   always #5 clk = ~clk;

   dsm_channel_scheduler #(
      .NUM_CH    (NUM_CH),
      .IN_WIDTH  (IN_WIDTH),
      .FRAC_BITS (FRAC_BITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .clear     (clear),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_sign  (out_sign),
`ifdef DSM_ERR_SAT_EN
      .sat_flag  (sat_flag),
`endif
      .busy      (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] sign_bits(input int s);
      if (s > 0) return 2'b01;
      if (s < 0) return 2'b11;
      return 2'b00;
   endfunction

   function automatic int wrap_err(input int x);
      int span;
      span = 1 << IN_WIDTH;
      return ((x - ERR_LO) % span + span) % span + ERR_LO;
   endfunction

   function automatic int winner();
      int c;
      if (m_mode != M_RUN || (m_ov != 0 && !out_ready)) return -1;
      for (int k = 1; k <= int'(NUM_CH); k++) begin
         c = (m_ptr + k) % NUM_CH;
         if (req_valid[c]) return c;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_mode = M_IDLE;
      m_cnt  = 0;
      m_ptr  = NUM_CH - 1;
      m_ov   = 0;
      m_ch   = 0;
      m_sign = 0;
      m_sat  = 0;
      for (int i = 0; i < int'(NUM_CH); i++) m_err[i] = 0;
   endtask

   task automatic set_data(input int ch, input int val);
      req_data[ch*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(val);
   endtask

   task automatic check_outputs();
      int w;
      w = winner();
      check_eq("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
      check_eq("out_valid", 32'(out_valid), 32'(m_ov));
      check_eq("out_ch", 32'(out_ch), 32'(m_ch));
      check_eq("out_sign", 32'(out_sign), 32'(sign_bits(m_sign)));
      check_eq("busy", 32'(busy), 32'(m_mode == M_DRAIN || m_mode == M_CLEAR));
`ifdef DSM_ERR_SAT_EN
      check_eq("sat_flag", 32'(sat_flag), 32'(m_sat));
`endif
   endtask

   // Advance the model across one rising edge using the currently driven inputs.
   task automatic model_step();
      int w, nmode, d, s, sg, ne;
      w = winner();
      nmode = m_mode;
      if (clear && m_mode != M_CLEAR) begin
         nmode = M_DRAIN;
      end else begin
         case (m_mode)
            M_IDLE:  if (enable) nmode = M_RUN;
            M_RUN:   if (!enable) nmode = M_IDLE;
            M_DRAIN: if (m_ov == 0 || out_ready) nmode = M_CLEAR;
            default: if (m_cnt == int'(NUM_CH) - 1) nmode = M_IDLE;
         endcase
      end
      if (m_mode == M_CLEAR) begin
         m_err[m_cnt] = 0;
         m_cnt++;
      end else begin
         m_cnt = 0;
      end
      if (nmode == M_CLEAR && m_mode != M_CLEAR) m_sat = 0;
      if (w >= 0) begin
         d  = $signed(req_data[w*IN_WIDTH +: IN_WIDTH]);
         s  = d + m_err[w];
         sg = (s > 0) ? 1 : ((s < 0) ? -1 : 0);
         ne = s - sg * (1 << FRAC_BITS);
`ifdef DSM_ERR_SAT_EN
         if (ne > ERR_HI) begin
            ne = ERR_HI;
            m_sat = 1;
         end else if (ne < ERR_LO) begin
            ne = ERR_LO;
            m_sat = 1;
         end
`else
         ne = wrap_err(ne);
`endif
         m_err[w] = ne;
         m_ptr    = w;
         m_ov     = 1;
         m_ch     = w;
         m_sign   = sg;
      end else if (out_ready) begin
         m_ov = 0;
      end
      m_mode = nmode;
   endtask

   // Inputs change 1 ns after the rising edge; outputs are sampled 4 ns after.
   task automatic tick();
      #3;
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      @(posedge clk);
      #1;
      #3 check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      tick();

      // Single channel, repeated 100: +1, -1, +1
      enable = 1'b1;
      out_ready = 1'b1;
      req_valid = 4'b0001;
      set_data(0, 100);
      tick();
      tick();
      check_eq("ch0_s1", 32'(out_sign), 32'h1);
      tick();
      check_eq("ch0_s2", 32'(out_sign), 32'h3);
      tick();
      check_eq("ch0_s3", 32'(out_sign), 32'h1);
      req_valid = '0;
      tick();

      // Zero and -1 on channel 1
      req_valid = 4'b0010;
      set_data(1, 0);
      tick();
      check_eq("zero_s", 32'(out_sign), 32'h0);
      set_data(1, -1);
      tick();
      check_eq("neg1_s", 32'(out_sign), 32'h3);
      set_data(1, 0);
      tick();
      check_eq("err511_s", 32'(out_sign), 32'h1);
      req_valid = '0;
      tick();

      // All channels requesting: round robin
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) set_data(i, 37 * i - 50);
      repeat (6) tick();

      // Backpressure then resume
      out_ready = 1'b0;
      repeat (3) tick();
      out_ready = 1'b1;
      repeat (3) tick();

      // Asynchronous reset while a result is pending
      out_ready = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      check_eq("rst_ov", 32'(out_valid), 32'h0);
      check_eq("rst_rr", 32'(req_ready), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      m_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      req_valid = 4'b0001;
      set_data(0, 100);
      out_ready = 1'b1;
      tick();
      tick();
      check_eq("post_rst_s", 32'(out_sign), 32'h1);

      // Clear with the result held for two cycles in DRAIN
      req_valid = '0;
      out_ready = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      check_eq("drain_busy", 32'(busy), 32'h1);
      tick();
      out_ready = 1'b1;
      enable = 1'b0;
      repeat (7) tick();
      enable = 1'b1;
      req_valid = 4'b0001;
      tick();
      tick();
      check_eq("post_clr_s", 32'(out_sign), 32'h1);
      req_valid = '0;
      tick();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         enable    = ($urandom_range(0, 15) != 0);
         clear     = ($urandom_range(0, 63) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         req_valid = NUM_CH'($urandom);
         for (int i = 0; i < int'(NUM_CH); i++) begin
            if ($urandom_range(0, 3) == 0) set_data(i, int'($urandom_range(0, 8191)) - 4096);
            else set_data(i, int'($urandom_range(0, 1400)) - 700);
         end
         tick();
      end
      clear = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dsm_channel_scheduler.md
Name: dsm_channel_scheduler

Overview:
- Time-multiplexes one first-order ternary noise-shaping datapath across NUM_CH antenna channels of the MIMO Tx delta-sigma modulator.
- Holds a per-channel error register file.
- Arbitrates channel sample requests round-robin and emits a tagged ternary sign stream.
- Sequences enable, drain and error-state clear through a small FSM.

Parameters:
NUM_CH, 4, number of channels sharing the datapath (power of 2, >=2)
IN_WIDTH, 13, signed sample and error width
FRAC_BITS, 9, fractional bits; quantiser step = 2^FRAC_BITS
CH_W, $clog2(NUM_CH), channel index width (derived, do not override)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
enable  in  1  run request; low stops new grants
clear  in  1  single-cycle pulse; zeroes all channel error state
req_valid  in  NUM_CH  per-channel sample valid
req_data  in  NUM_CH*IN_WIDTH  signed samples; channel i at bits [i*IN_WIDTH +: IN_WIDTH]
req_ready  out  NUM_CH  one-hot grant; transfer when req_valid[i] & req_ready[i]
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_ch  out  CH_W  channel of result
out_sign  out  2  ternary sign, 2's complement: 01=+1, 00=0, 11=-1
busy  out  1  high in DRAIN and CLEAR

Behaviour:
- Reset (rst low, async): state IDLE; all err[i]=0; rr pointer = NUM_CH-1, so channel 0 wins first; out_valid=0; out_ch=0; out_sign=00; req_ready=0; busy=0.
- FSM states and transitions:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0.
  - Any state except CLEAR -> DRAIN on clear=1. clear takes priority over enable.
  - DRAIN -> CLEAR when out_valid=0, or when out_valid & out_ready.
  - CLEAR: counter 0..NUM_CH-1 zeroes err[counter], one per cycle; -> IDLE after the last entry.
  - clear pulses seen during CLEAR are ignored.
- Grant: allowed only in RUN, and only when out_valid=0 or out_ready=1.
  - Winner is the first requesting channel after the rr pointer, wrapping.
  - Pointer updates to the winner only on a transfer.
  - req_ready is combinational and one-hot; it may depend on req_valid.
- Datapath, evaluated in the transfer cycle for channel c:
  - sum = sext(req_data[c]) + sext(err[c]), IN_WIDTH+1 bits, signed.
  - sign: sum==0 -> 00; sum MSB=1 -> 11; otherwise -> 01.
  - new_err = sum - sext(sign)*2^FRAC_BITS, truncated to IN_WIDTH (wrap).
  - err[c] <= new_err at the same edge.
- Latency: transfer at edge k -> out_valid=1, out_ch=c, out_sign=sign after edge k.
- Output register holds stable while out_valid & !out_ready.
- Back-to-back grants to the same channel are correct with no bubble, because err updates at the transfer edge.
- RUN -> IDLE with out_valid=1: the result stays valid until it is consumed.
- Channels with req_valid=0 keep their err untouched.

Optional Feature:
- Macro DSM_ERR_SAT_EN.
- Defined: new_err is clamped to [-2^(IN_WIDTH-1), 2^(IN_WIDTH-1)-1] instead of wrapping, and a sticky output sat_flag (1 bit) rises on any clamp. sat_flag clears on reset or on entering CLEAR.
- Undefined: wrap behaviour as above; no sat_flag port.

Decomposition:
- Package dsm_sched_pkg holds:
  - state enum {IDLE, RUN, DRAIN, CLEAR};
  - SIGN_POS=2'b01, SIGN_ZERO=2'b00, SIGN_NEG=2'b11;
  - the ternary-decision function (sum -> sign).
- One sub-module, dsm_rr_arbiter: NUM_CH request vector, pointer in, one-hot grant out, winner index out.

Test Plan:
- Reset: assert rst low mid-RUN with out_valid=1 -> out_valid=0, req_ready=0, busy=0 immediately; after release, ch0 with data 100 gives sign 01.
- Single channel ch0, enable=1, data 100,100,100 (out_ready=1):
  - signs 01,11,01;
  - err -412, 200, -212;
  - each result appears one cycle after its transfer.
- Zero input: ch1 data 0 with err 0 -> sign 00, err stays 0; a negative input of -1 gives sign 11 and err 511.
- All 4 req_valid high, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; out_ch follows with 1-cycle lag.
- Backpressure: out_ready=0 while out_valid=1 -> req_ready=0000 and out_ch/out_sign stable; out_ready=1 resumes from the next rr channel.
- Clear mid-stream after ch0 err=-412 (out_ready=0 for 2 cycles during DRAIN):
  - busy=1, no grants;
  - 4 CLEAR cycles, then IDLE;
  - re-enable, ch0 data 100 -> sign 01, err -412.
